// File: rtl/gf_serial_mult4.sv
// Bit-serial GF(2^m) multiplier (m = 2..W) using MSB-first Horner reduction.
// One product per start/busy/done transaction; all outputs are registered.
module gf_serial_mult4 #(
  parameter int W  = 4,
  parameter int MW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] m,
  input  logic [W:0]    prim_poly,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  product,
  output logic          err
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [MW-1:0] m_r;
  logic [W-1:0]  poly_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc_nxt;

  // Mask of the m low-order bits; the shift wraps cleanly for m == W.
  function automatic logic [W-1:0] mask_of(input logic [MW-1:0] fm);
    logic [W:0] one_hot;
    one_hot = (W+1)'(1) << fm;
    return one_hot[W-1:0] - W'(1);
  endfunction

  function automatic logic field_ok(input logic [MW-1:0] fm, input logic [W:0] poly,
                                    input logic [W-1:0] fa, input logic [W-1:0] fb);
    logic [W-1:0] mk;
    logic         ok;
    mk = mask_of(fm);
    ok = (fm >= MW'(2)) && (fm <= MW'(W));
    if (ok) begin
      ok = poly[fm] && poly[0] && ((poly >> (fm + MW'(1))) == '0) &&
           ((fa & ~mk) == '0) && ((fb & ~mk) == '0);
    end
    return ok;
  endfunction

  // One Horner step: multiply accumulator by x, reduce, then add a if this b bit is set.
  function automatic logic [W-1:0] horner_step(input logic [W-1:0] acc_v, input logic [W-1:0] mk,
                                               input logic [W-1:0] poly_lo, input logic [W-1:0] fa,
                                               input logic msb, input logic bit_b);
    logic [W-1:0] xt;
    xt = ((acc_v << 1) & mk) ^ (msb ? (poly_lo & mk) : '0);
    return xt ^ (bit_b ? fa : '0);
  endfunction

  always_comb begin
    acc_nxt = horner_step(acc, mask_of(m_r), poly_r, a_r, acc[m_r - MW'(1)], b_r[cnt]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      err     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      m_r     <= '0;
      poly_r  <= '0;
      a_r     <= '0;
      b_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_r     <= m;
            poly_r  <= prim_poly[W-1:0];
            a_r     <= a;
            b_r     <= b;
            acc     <= '0;
            product <= '0;
            if (field_ok(m, prim_poly, a, b)) begin
              cnt   <= CW'(m - MW'(1));
              busy  <= 1'b1;
              err   <= 1'b0;
              state <= CALC;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (cnt == '0) begin
            product <= acc_nxt;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_serial_mult4.sv
// Bench for gf_serial_mult4: directed field cases plus randomized traffic
// checked every cycle against a transaction-level GF multiply model.
module tb_gf_serial_mult4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] m = 3'd0;
  logic [4:0] prim_poly = 5'd0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       busy;
  logic       done;
  logic [3:0] product;
  logic       err;

  int tests = 0;
  int fails = 0;

  gf_serial_mult4 #(.W(4), .MW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .prim_poly(prim_poly),
    .a(a), .b(b), .busy(busy), .done(done), .product(product), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Polynomial product over GF(2), then reduction by the degree-m modulus.
  function automatic int gf_mul(input int mm, input int pp, input int aa, input int bb);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++)
      if (((bb >> i) & 1) == 1) p = p ^ (aa << i);
    for (int i = 6; i >= mm; i--)
      if (((p >> i) & 1) == 1) p = p ^ (pp << (i - mm));
    return p;
  endfunction

  function automatic bit field_valid(input int mm, input int pp, input int aa, input int bb);
    if (mm < 2 || mm > 4) return 1'b0;
    if (((pp >> mm) & 1) == 0 || (pp & 1) == 0) return 1'b0;
    if ((pp >> (mm + 1)) != 0) return 1'b0;
    if (aa >= (1 << mm) || bb >= (1 << mm)) return 1'b0;
    return 1'b1;
  endfunction

  // Model timeline in edge numbers: an accept at edge E gives busy after edges
  // E..E+m-1, done after edge E+m, and the next accept no earlier than edge E+m+2.
  int  edge_n = 0;
  int  busy_lo = 1, busy_hi = 0;
  int  done_edge = -100;
  int  rst_edge = -100;
  int  exp_p = 0, exp_e = 0;
  bit  armed = 1'b0;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      armed = 1'b1;
      busy_lo = 1; busy_hi = 0;
      done_edge = -100;
      rst_edge = edge_n;
    end else if (start && edge_n >= done_edge + 2) begin
      if (field_valid(int'(m), int'(prim_poly), int'(a), int'(b))) begin
        busy_lo = edge_n;
        busy_hi = edge_n + int'(m) - 1;
        done_edge = edge_n + int'(m);
        exp_p = gf_mul(int'(m), int'(prim_poly), int'(a), int'(b));
        exp_e = 0;
      end else begin
        busy_lo = 1; busy_hi = 0;
        done_edge = edge_n;
        exp_p = 0;
        exp_e = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", int'(busy), int'(edge_n >= busy_lo && edge_n <= busy_hi));
      chk("done", int'(done), int'(edge_n == done_edge));
      if (edge_n == done_edge) begin
        chk("product", int'(product), exp_p);
        chk("err", int'(err), exp_e);
      end
      if (edge_n == rst_edge) begin
        chk("rst_product", int'(product), 0);
        chk("rst_err", int'(err), 0);
      end
    end
  end

  task automatic run_op(input int mm, input int pp, input int aa, input int bb,
                        input int ep, input int ee, input bit hold);
    int lat;
    lat = 0;
    @(negedge clk);
    m = 3'(mm); prim_poly = 5'(pp); a = 4'(aa); b = 4'(bb); start = 1'b1;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (hold) begin
        a = 4'($urandom); b = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) lat = k;
    end
    start = 1'b0;
    chk("latency", lat, (ee != 0) ? 1 : mm + 1);
    chk("lit_product", int'(product), ep);
    chk("lit_err", int'(err), ee);
  endtask

  function automatic int pick_poly(input int mm);
    int r;
    r = $urandom_range(0, 1);
    case (mm)
      2: return 'h07;
      3: return (r == 0) ? 'h0B : 'h0D;
      4: return (r == 0) ? 'h13 : 'h19;
      default: return $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    int mm;
    chk("pin_mul_3x2", gf_mul(3, 'h0B, 3, 2), 6);
    chk("pin_mul_Ax6", gf_mul(4, 'h13, 'hA, 6), 9);
    chk("pin_mul_7x4", gf_mul(3, 'h0B, 7, 4), 1);
    chk("pin_valid_bad", int'(field_valid(3, 'h10, 1, 1)), 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(3, 'h0B, 3, 2, 6, 0, 1'b0);
    run_op(3, 'h0B, 7, 4, 1, 0, 1'b0);
    run_op(4, 'h13, 'hA, 6, 9, 0, 1'b0);
    run_op(2, 'h07, 2, 2, 3, 0, 1'b0);
    run_op(2, 'h07, 0, 3, 0, 0, 1'b0);
    run_op(4, 'h13, 1, 'hB, 'hB, 0, 1'b0);
    run_op(3, 'h10, 1, 1, 0, 1, 1'b0);
    run_op(3, 'h0B, 8, 1, 0, 1, 1'b0);
    run_op(5, 'h1F, 1, 1, 0, 1, 1'b0);
    run_op(4, 'h13, 'hA, 6, 9, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_done", int'(done), 0);
    end

    // Reset lands on the edge ending cycle 2 of an m=4 operation.
    @(negedge clk);
    m = 3'd4; prim_poly = 5'h13; a = 4'hA; b = 4'h6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_product", int'(product), 0);
    chk("mid_rst_err", int'(err), 0);
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_no_done", int'(done), 0);
    end
    run_op(3, 'h0B, 3, 2, 6, 0, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) != 0);
      mm = ($urandom_range(0, 99) < 85) ? $urandom_range(2, 4) : $urandom_range(0, 7);
      m = 3'(mm);
      prim_poly = ($urandom_range(0, 9) < 8) ? 5'(pick_poly(mm)) : 5'($urandom_range(0, 31));
      if (mm >= 2 && mm <= 4 && $urandom_range(0, 99) < 90) begin
        a = 4'($urandom_range(0, (1 << mm) - 1));
        b = 4'($urandom_range(0, (1 << mm) - 1));
      end else begin
        a = 4'($urandom);
        b = 4'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gf_serial_mult4.md
Name: gf_serial_mult4

Overview:
- Bit-serial GF(2^m) multiplier, m = 2..4, sitting directly downstream of the 4-bit GF adder stage; it consumes the adder's output element as operand a and multiplies it by a second field element b under the same m / prim_poly field description.
- Computes one product per transaction with a start/busy/done handshake, using MSB-first Horner reduction.
- Field validity checking matches the adder stage's field conventions.

Parameters:
- W, 4, maximum field width and element width; all element ports are W bits.
- MW, 3, width of the field-degree input m.

Ports:
- clk        input   1   single clock, rising-edge.
- rst        input   1   reset, synchronous, active-high.
- start      input   1   request; sampled only in IDLE.
- m          input   3   field degree, legal 2..4.
- prim_poly  input   5   primitive polynomial; bit i = coefficient of x^i.
- a          input   4   operand element, typically the adder's opelement.
- b          input   4   operand element.
- busy       output  1   high while a multiplication is in progress.
- done       output  1   one-cycle pulse; product and err are valid in that cycle.
- product    output  4   a*b mod prim_poly; held until the next accepted start.
- err        output  1   high with done when the field or operands are illegal; held like product.

Behaviour:
- Reset, any cycle including mid-operation:
  - State goes to IDLE.
  - busy=0, done=0, product=0, err=0, accumulator=0, bit counter=0.
  - Any in-flight operation is discarded with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at the rising edge ending cycle 0:
  - Latch m, prim_poly, a, b.
  - Evaluate validity on the latched values:
    - m in {2,3,4};
    - prim_poly[m]=1 and prim_poly[0]=1;
    - prim_poly bits above m = 0;
    - a < 2^m and b < 2^m.
  - Valid: acc=0, cnt=m-1, go to CALC.
  - Invalid: go to DONE with product=0, err=1, so done=1 in cycle 1.
- CALC: one step per clock, for cnt = m-1 down to 0.
  - xt = (acc<<1) masked to m bits, XOR (prim_poly[m-1:0] if acc[m-1]=1, else 0).
  - acc = xt XOR (b[cnt] ? a : 0).
  - When cnt=0: product=next acc, err=0, go to DONE. Otherwise decrement cnt.
  - busy=1 in cycles 1..m.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - Valid op: done in cycle m+1.
  - Earliest next start is sampled in cycle m+2.
- start while in CALC or DONE is ignored; no queueing.
- Input changes after cycle 0 have no effect (operands latched).
- Unused high product bits (bit >= m) are always 0.
- a=0 or b=0 gives product 0 with err=0.
- Multiplication by 1 returns the other operand.
- Result is combinational-free: product, done, busy and err are all registered outputs.

Test Plan:
- m=3, prim_poly=01011, a=3, b=2, start pulse -> busy cycles 1..3, done in cycle 4, product=6, err=0.
- m=3, prim_poly=01011, a=7, b=4 -> product=1. Then back-to-back at the earliest start: m=4, prim_poly=10011, a=A, b=6 -> done in cycle 5, product=9.
- m=2, prim_poly=00111, a=2, b=2 -> done in cycle 3, product=3; also a=0, b=3 -> product=0, err=0.
- Error cases, each giving done in cycle 1, err=1, product=0:
  - m=3, prim_poly=10000;
  - m=3, prim_poly=01011, a=8;
  - m=5, any poly.
- Start held high during CALC, plus operand changes mid-op on the m=4 case -> single done, product=9, no second transaction until IDLE.
- rst asserted in cycle 2 of an m=4 op:
  - Next cycle: busy=0, done=0, product=0, err=0, and no done pulse follows.
  - A fresh m=3, prim_poly=01011, a=3, b=2 request then yields product=6.
